// File: rtl/pc_ctrl_pkg.sv
// Shared types for the eBPF program-counter controller: op encoding,
// run-state encoding and the op-field width.
package pc_ctrl_pkg;

    localparam int OP_W = 3;

    // Codes 6 and 7 are not listed and decode as NEXT.
    typedef enum logic [OP_W-1:0] {
        OP_NEXT  = 3'd0,
        OP_JA    = 3'd1,
        OP_JCOND = 3'd2,
        OP_CALL  = 3'd3,
        OP_EXIT  = 3'd4,
        OP_LOAD  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address stack: a LIFO of PC values with push/pop/clear
// and a combinational view of the top entry.
module ret_stack
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 8,
    localparam int DEPTH_W  = $clog2(RAS_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  logic [PC_W-1:0]    push_data,
    output logic [PC_W-1:0]    top,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    // A single-entry stack still gets a 1-bit index and a 2-entry array.
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int ARR_N = (RAS_DEPTH > 1) ? RAS_DEPTH : 2;

    logic [PC_W-1:0]    entries_q [ARR_N];
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic               do_push;
    logic               do_pop;

    assign full    = (depth_q == DEPTH_W'(RAS_DEPTH));
    assign empty   = (depth_q == '0);
    assign wr_idx  = depth_q[IDX_W-1:0];
    assign rd_idx  = wr_idx - IDX_W'(1);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_comb begin
        depth_d = depth_q;
        if (clear) begin
            depth_d = '0;
        end else if (do_push) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (do_pop) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entry storage carries no reset; only slots below depth are ever read.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            entries_q[wr_idx] <= push_data;
        end
    end

    assign top   = entries_q[rd_idx];
    assign depth = depth_q;

endmodule

// File: rtl/pc_ctrl.sv
// eBPF program-counter controller: fetch address generation, PC-relative
// jumps, CALL/EXIT through the return-address stack, RUN/HALT/FAULT tracking.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int          PC_W      = 32,
    parameter int          OFF_W     = 16,
    parameter int          RAS_DEPTH = 8,
    parameter int unsigned RESET_PC  = 0,
    localparam int         DEPTH_W   = $clog2(RAS_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [OP_W-1:0]    op,
    input  logic               cond,
    input  logic [OFF_W-1:0]   off,
    input  logic [PC_W-1:0]    imm,
    input  logic [PC_W-1:0]    load_addr,
    output logic [PC_W-1:0]    pc,
    output logic               pc_valid,
    output logic               halted,
    output logic               fault,
    output logic [DEPTH_W-1:0] ras_depth,
    output logic [1:0]         dbg_state
);

    // en is a qualifier, not a handshake: with en=0 every input is ignored
    // and all state holds; with en=1 exactly one op executes at the next edge.

    state_e           state_q;
    state_e           state_d;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic             pc_valid_q;
    logic             halted_q;
    logic             fault_q;

    logic [PC_W-1:0]  pc_plus1;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  rel_target;
    logic [PC_W-1:0]  call_target;

    logic             stk_push;
    logic             stk_pop;
    logic             stk_clear;
    logic [PC_W-1:0]  stk_top;
    logic [DEPTH_W-1:0] stk_depth;
    logic             stk_full;
    logic             stk_empty;

    // Sign-extend (or wrap, when PC_W < OFF_W) the eBPF offset to PC width.
    assign off_ext     = PC_W'($signed(off));
    assign pc_plus1    = pc_q + PC_W'(1);
    assign rel_target  = pc_plus1 + off_ext;
    assign call_target = pc_plus1 + imm;

    ret_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .clear     (stk_clear),
        .push_data (pc_plus1),
        .top       (stk_top),
        .depth     (stk_depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        pc_d      = pc_q;
        state_d   = state_q;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clear = 1'b0;
        if (en) begin
            if (op == OP_LOAD) begin
                pc_d      = load_addr;
                state_d   = ST_RUN;
                stk_clear = 1'b1;
            end else if (state_q == ST_RUN) begin
                case (op)
                    OP_JA: begin
                        pc_d = rel_target;
                    end
                    OP_JCOND: begin
                        pc_d = cond ? rel_target : pc_plus1;
                    end
                    OP_CALL: begin
                        // Overflow discards the push and freezes pc.
                        if (stk_full) begin
                            state_d = ST_FAULT;
                        end else begin
                            stk_push = 1'b1;
                            pc_d     = call_target;
                        end
                    end
                    OP_EXIT: begin
                        if (stk_empty) begin
                            state_d = ST_HALT;
                        end else begin
                            stk_pop = 1'b1;
                            pc_d    = stk_top;
                        end
                    end
                    default: begin
                        pc_d = pc_plus1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= PC_W'(RESET_PC);
            pc_valid_q <= 1'b1;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= (state_d == ST_RUN);
            halted_q   <= (state_d == ST_HALT);
            fault_q    <= (state_d == ST_FAULT);
        end
    end

    assign pc        = pc_q;
    assign pc_valid  = pc_valid_q;
    assign halted    = halted_q;
    assign fault     = fault_q;
    assign ras_depth = stk_depth;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: a default-size instance (a) and an 8-bit,
// two-entry-stack instance (b) driven from hand-computed vectors.
module tb_pc_ctrl;

    logic clk;

    logic        a_rst, a_en, a_cond;
    logic [2:0]  a_op;
    logic [15:0] a_off;
    logic [31:0] a_imm, a_load;
    logic [31:0] a_pc;
    logic        a_valid, a_halted, a_fault;
    logic [3:0]  a_depth;
    logic [1:0]  a_state;

    logic        b_rst, b_en, b_cond;
    logic [2:0]  b_op;
    logic [15:0] b_off;
    logic [7:0]  b_imm, b_load;
    logic [7:0]  b_pc;
    logic        b_valid, b_halted, b_fault;
    logic [1:0]  b_depth;
    logic [1:0]  b_state;

    int tests_run;
    int tests_failed;

    localparam logic [2:0] NEXT = 3'd0, JA = 3'd1, JCOND = 3'd2,
                           CALL = 3'd3, EXIT = 3'd4, LOAD = 3'd5;

    pc_ctrl u_a (
        .clk       (clk),
        .rst       (a_rst),
        .en        (a_en),
        .op        (a_op),
        .cond      (a_cond),
        .off       (a_off),
        .imm       (a_imm),
        .load_addr (a_load),
        .pc        (a_pc),
        .pc_valid  (a_valid),
        .halted    (a_halted),
        .fault     (a_fault),
        .ras_depth (a_depth),
        .dbg_state (a_state)
    );

    pc_ctrl #(
        .PC_W      (8),
        .OFF_W     (16),
        .RAS_DEPTH (2),
        .RESET_PC  (0)
    ) u_b (
        .clk       (clk),
        .rst       (b_rst),
        .en        (b_en),
        .op        (b_op),
        .cond      (b_cond),
        .off       (b_off),
        .imm       (b_imm),
        .load_addr (b_load),
        .pc        (b_pc),
        .pc_valid  (b_valid),
        .halted    (b_halted),
        .fault     (b_fault),
        .ras_depth (b_depth),
        .dbg_state (b_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic drive_a(input logic [2:0] o, input logic c, input logic [15:0] of,
                           input logic [31:0] im, input logic [31:0] la);
        a_en = 1'b1; a_op = o; a_cond = c; a_off = of; a_imm = im; a_load = la;
        tick();
        a_en = 1'b0; a_op = NEXT;
    endtask

    task automatic drive_b(input logic [2:0] o, input logic [15:0] of,
                           input logic [7:0] im, input logic [7:0] la);
        b_en = 1'b1; b_op = o; b_cond = 1'b0; b_off = of; b_imm = im; b_load = la;
        tick();
        b_en = 1'b0; b_op = NEXT;
    endtask

    task automatic expect_a(input string tag, input logic [31:0] pc, input logic [3:0] depth,
                            input logic valid, input logic hlt, input logic flt);
        check({tag, ".pc"}, a_pc, pc);
        check({tag, ".depth"}, {28'd0, a_depth}, {28'd0, depth});
        check({tag, ".valid"}, {31'd0, a_valid}, {31'd0, valid});
        check({tag, ".halted"}, {31'd0, a_halted}, {31'd0, hlt});
        check({tag, ".fault"}, {31'd0, a_fault}, {31'd0, flt});
    endtask

    task automatic expect_b(input string tag, input logic [7:0] pc, input logic [1:0] depth,
                            input logic valid, input logic flt);
        check({tag, ".pc"}, {24'd0, b_pc}, {24'd0, pc});
        check({tag, ".depth"}, {30'd0, b_depth}, {30'd0, depth});
        check({tag, ".valid"}, {31'd0, b_valid}, {31'd0, valid});
        check({tag, ".fault"}, {31'd0, b_fault}, {31'd0, flt});
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        a_rst = 1'b1; a_en = 1'b0; a_op = NEXT; a_cond = 1'b0; a_off = '0; a_imm = '0; a_load = '0;
        b_rst = 1'b1; b_en = 1'b0; b_op = NEXT; b_cond = 1'b0; b_off = '0; b_imm = '0; b_load = '0;
        tick();
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;
        expect_a("reset", 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        check("reset.state", {30'd0, a_state}, 32'd0);

        // sequential steps, then en=0 holds even for LOAD
        for (int i = 1; i <= 5; i++) begin
            drive_a(NEXT, 1'b0, 16'd0, 32'd0, 32'd0);
            check($sformatf("next%0d", i), a_pc, 32'(i));
        end
        a_en = 1'b0; a_op = LOAD; a_load = 32'h99;
        tick();
        tick();
        a_op = NEXT;
        check("en_low_hold", a_pc, 32'd5);

        // undefined op code 7 steps like NEXT
        drive_a(3'd7, 1'b0, 16'd0, 32'd0, 32'd0);
        check("op7_next", a_pc, 32'd6);

        // relative jumps
        drive_a(LOAD, 1'b0, 16'd0, 32'd0, 32'd10);
        check("load10", a_pc, 32'd10);
        drive_a(JA, 1'b0, 16'hFFFD, 32'd0, 32'd0);
        check("ja_m3", a_pc, 32'd8);
        drive_a(JCOND, 1'b0, 16'd4, 32'd0, 32'd0);
        check("jcond_nt", a_pc, 32'd9);
        drive_a(LOAD, 1'b0, 16'd0, 32'd0, 32'd8);
        drive_a(JCOND, 1'b1, 16'd4, 32'd0, 32'd0);
        check("jcond_t", a_pc, 32'd13);

        // call chain and return
        drive_a(LOAD, 1'b0, 16'd0, 32'd0, 32'd20);
        drive_a(CALL, 1'b0, 16'd0, 32'd100, 32'd0);
        expect_a("call1", 32'd121, 4'd1, 1'b1, 1'b0, 1'b0);
        drive_a(CALL, 1'b0, 16'd0, 32'd5, 32'd0);
        expect_a("call2", 32'd127, 4'd2, 1'b1, 1'b0, 1'b0);
        drive_a(EXIT, 1'b0, 16'd0, 32'd0, 32'd0);
        expect_a("exit1", 32'd122, 4'd1, 1'b1, 1'b0, 1'b0);
        drive_a(EXIT, 1'b0, 16'd0, 32'd0, 32'd0);
        expect_a("exit2", 32'd21, 4'd0, 1'b1, 1'b0, 1'b0);
        drive_a(EXIT, 1'b0, 16'd0, 32'd0, 32'd0);
        expect_a("exit_halt", 32'd21, 4'd0, 1'b0, 1'b1, 1'b0);
        check("halt.state", {30'd0, a_state}, 32'd1);
        drive_a(JA, 1'b0, 16'd7, 32'd0, 32'd0);
        expect_a("halt_ignore", 32'd21, 4'd0, 1'b0, 1'b1, 1'b0);
        drive_a(LOAD, 1'b0, 16'd0, 32'd0, 32'h40);
        expect_a("halt_load", 32'h40, 4'd0, 1'b1, 1'b0, 1'b0);

        // reset in the middle of a call chain
        drive_a(LOAD, 1'b0, 16'd0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) drive_a(CALL, 1'b0, 16'd0, 32'd1, 32'd0);
        expect_a("chain3", 32'd6, 4'd3, 1'b1, 1'b0, 1'b0);
        a_rst = 1'b1; a_en = 1'b1; a_op = CALL;
        tick();
        a_rst = 1'b0; a_en = 1'b0; a_op = NEXT;
        expect_a("mid_rst", 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        drive_a(EXIT, 1'b0, 16'd0, 32'd0, 32'd0);
        expect_a("rst_exit", 32'd0, 4'd0, 1'b0, 1'b1, 1'b0);

        // small instance: stack overflow and 8-bit wrap
        expect_b("b_reset", 8'd0, 2'd0, 1'b1, 1'b0);
        drive_b(LOAD, 16'd0, 8'd0, 8'h10);
        drive_b(CALL, 16'd0, 8'd1, 8'd0);
        expect_b("b_call1", 8'h12, 2'd1, 1'b1, 1'b0);
        drive_b(CALL, 16'd0, 8'd1, 8'd0);
        expect_b("b_call2", 8'h14, 2'd2, 1'b1, 1'b0);
        drive_b(CALL, 16'd0, 8'd1, 8'd0);
        expect_b("b_overflow", 8'h14, 2'd2, 1'b0, 1'b1);
        check("b_fault.state", {30'd0, b_state}, 32'd2);
        drive_b(NEXT, 16'd0, 8'd0, 8'd0);
        expect_b("b_fault_ignore", 8'h14, 2'd2, 1'b0, 1'b1);
        drive_b(LOAD, 16'd0, 8'd0, 8'h40);
        expect_b("b_fault_load", 8'h40, 2'd0, 1'b1, 1'b0);
        drive_b(LOAD, 16'd0, 8'd0, 8'hFE);
        drive_b(NEXT, 16'd0, 8'd0, 8'd0);
        check("b_wrap_ff", {24'd0, b_pc}, 32'hFF);
        drive_b(NEXT, 16'd0, 8'd0, 8'd0);
        check("b_wrap_00", {24'd0, b_pc}, 32'h00);
        drive_b(JA, 16'hFFFF, 8'd0, 8'd0);
        expect_b("b_ja_m1", 8'h00, 2'd0, 1'b1, 1'b0);

        // report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
